instr_align_stage: RTL
======================

// Module: instr_align_stage
// PURPOSE
//  IF->ID realignment stage. Consumes the word-aligned 32-bit fetch word and PC from the fetch stage.
//  Splits mixed 16/32-bit streams (RVC) into individual instructions, including 32-bit instructions
//  that straddle a word boundary. Drives o_incr_pc back to fetch and presents one registered
//  instruction + PC + flags per cycle to ID.
// PARAMETERS
//  XLEN      64  PC width
//  ILEN      32  fetch word / max instruction width
//  HW_BITS   16  halfword width (RVC parcel)
// PORTS
//  clk                 in   1     clock
//  rst_n               in   1     asynchronous active-low reset
//  i_if_instr          in   ILEN  fetch word at i_if_pc (sync-mem output, same cycle as i_if_pc)
//  i_if_pc             in   XLEN  word-aligned fetch PC (bits[1:0]=0)
//  i_if_valid_instr    in   1     fetch word valid
//  i_id_ready          in   1     ID accepts o_id_* this cycle
//  i_flush             in   1     branch/jump taken in EX (OR of both)
//  i_redirect_hw       in   1     bit[1] of the branch/jump target (halfword offset), sampled with i_flush
//  o_incr_pc           out  1     comb: 1 = fetch advances to next word, 0 = re-present current word
//  o_id_instr          out  ILEN  instruction; 16-bit instrs zero-extended in [31:16]
//  o_id_pc             out  XLEN  byte PC of instruction (may have bit[1]=1)
//  o_id_valid          out  1     o_id_* valid
//  o_id_compressed     out  1     o_id_instr is 16-bit
// BEHAVIOUR
//  Reset (async): state=ALIGNED, hw_buf=0, hw_buf_pc=0, o_id_instr=0, o_id_pc=0, o_id_valid=0, o_id_compressed=0.
//  Parcel is compressed iff parcel[1:0]!=2'b11. Output register latency: 1 cycle after the word is accepted.
//  FSM (advances only when i_if_valid_instr & i_id_ready & ~i_flush):
//   ALIGNED: lo=word[15:0].
//    lo compressed -> emit {16'h0,lo} @pc, compressed=1, incr=0, ->UPPER.
//    otherwise     -> emit word @pc, incr=1, stay ALIGNED.
//   UPPER: hi=word[31:16].
//    hi compressed -> emit {16'h0,hi} @pc+2, incr=1, ->ALIGNED.
//    otherwise     -> hw_buf<=hi, hw_buf_pc<=pc+2, no emit (o_id_valid<=0), incr=1, ->SPLIT.
//   SPLIT: emit {word[15:0],hw_buf} @hw_buf_pc, compressed=0, incr=0, ->UPPER.
//  Stall (~i_id_ready): all state and o_id_* hold; o_incr_pc=0.
//  ~i_if_valid_instr without flush: state holds; o_id_valid<=0 once ID accepts; o_incr_pc=0.
//  i_flush (priority over everything): o_id_valid<=0; hw_buf discarded.
//   state <= i_redirect_hw ? UPPER : ALIGNED.
//   The first word after a redirect to pc+2 skips its low half.
//  Flush in SPLIT discards the buffered upper half; no partial instruction is ever emitted.
//  PC arithmetic is XLEN-wide modulo 2^XLEN; pc+2 at 64'hFFFF_FFFF_FFFF_FFFE wraps to 0.
//  Reset mid-operation: immediate return to reset values; o_incr_pc=0 while rst_n=0.
//  Invariant: o_id_valid=1 never coincides with state=SPLIT on entry from UPPER.
// CONFIGURATION
//  INSTR_ALIGN_RVC_EN defined: full FSM above.
//  INSTR_ALIGN_RVC_EN undefined:
//   - Every parcel is treated as 32-bit; state fixed at ALIGNED.
//   - o_incr_pc = i_id_ready & i_if_valid_instr; o_id_compressed=0.
//   - i_redirect_hw is ignored; hw_buf is not instantiated.
// STRUCTURE
//  struct_pckg: add align_state_e {ALIGNED, UPPER, SPLIT}.
//  struct_pckg: add if_id_payload_t {instr, pc, valid, compressed}.
//  struct_pckg: add constant HW_BYTES=2.
//  Sub-module if_id_pipe_reg: payload register with hold-on-stall and clear-on-flush, async reset.
//  FSM, parcel decode and o_incr_pc logic stay in instr_align_stage.
// TESTING
//  1. Words 0x00000013 @0x100, 0x00100093 @0x104 -> emits 0x13 @0x100, 0x00100093 @0x104; compressed=0, incr=1 each.
//  2. Word 0x00014501 @0x100 (lo c.li, hi c.nop) -> emits 0x4501 @0x100 (incr=0), then 0x0001 @0x102 (incr=1).
//  3. Word 0x00934501 @0x100, then 0x00130000 @0x104 -> emits 0x4501 @0x100, no output for 1 cycle,
//     then 0x00000093 @0x102 (compressed=0), then UPPER on 0x104.
//  4. i_flush=1, i_redirect_hw=1 while in SPLIT, next word 0x45010000 @0x200 -> buffer dropped,
//     first output 0x4501 @0x202.
//  5. i_id_ready=0 for 3 cycles mid-stream -> o_id_* and state stable, o_incr_pc=0; resumes with no loss or duplicates.
//  6. rst_n pulsed low in UPPER -> all outputs 0 asynchronously; after release first emit @0x100 from ALIGNED.

Source files
------------

// File: rtl/instr_align_stage_pkg.sv
// Shared types and constants for the IF->ID realignment stage.
// The RVC split/merge path is built only when INSTR_ALIGN_RVC_EN is defined.
package instr_align_stage_pkg;

   localparam int XLEN     = 64;
   localparam int ILEN     = 32;
   localparam int HW_BITS  = 16;
   localparam int HW_BYTES = 2;

   typedef enum logic [1:0] {
      ALIGNED = 2'd0,
      UPPER   = 2'd1,
      SPLIT   = 2'd2
   } align_state_e;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic            valid;
      logic            compressed;
   } if_id_payload_t;

   // A parcel starts a 32-bit instruction only when its two low bits are both set.
   function automatic logic is_compressed(input logic [1:0] parcel_lsb);
      return parcel_lsb != 2'b11;
   endfunction

endpackage

// File: rtl/instr_align_stage_if_id_pipe_reg.sv
// IF->ID payload register: flush clears valid, stall holds, otherwise loads or drops valid.
module if_id_pipe_reg
   import instr_align_stage_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_flush,
   input  logic            i_hold,
   input  logic            i_load,
   input  logic [ILEN-1:0] i_instr,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_valid,
   input  logic            i_compressed,
   output logic [ILEN-1:0] o_instr,
   output logic [XLEN-1:0] o_pc,
   output logic            o_valid,
   output logic            o_compressed
);

   if_id_payload_t payload_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         payload_q <= '0;
      end else if (i_flush) begin
         payload_q.valid <= 1'b0;
      end else if (!i_hold) begin
         if (i_load) begin
            payload_q.instr      <= i_instr;
            payload_q.pc         <= i_pc;
            payload_q.valid      <= i_valid;
            payload_q.compressed <= i_compressed;
         end else begin
            payload_q.valid <= 1'b0;
         end
      end
   end

   assign o_instr      = payload_q.instr;
   assign o_pc         = payload_q.pc;
   assign o_valid      = payload_q.valid;
   assign o_compressed = payload_q.compressed;

endmodule

// File: rtl/instr_align_stage.sv
// IF->ID realignment: splits 16/32-bit parcels from word-aligned fetch into one instruction per cycle.
// Define INSTR_ALIGN_RVC_EN to enable compressed-instruction handling; otherwise every word is one instruction.
module instr_align_stage
   import instr_align_stage_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [ILEN-1:0] i_if_instr,
   input  logic [XLEN-1:0] i_if_pc,
   input  logic            i_if_valid_instr,
   input  logic            i_id_ready,
   input  logic            i_flush,
   input  logic            i_redirect_hw,
   output logic            o_incr_pc,
   output logic [ILEN-1:0] o_id_instr,
   output logic [XLEN-1:0] o_id_pc,
   output logic            o_id_valid,
   output logic            o_id_compressed,
   output logic [1:0]      o_dbg_state
);

   // Handshake: a fetch word is consumed only on a cycle with i_if_valid_instr & i_id_ready & ~i_flush;
   // o_incr_pc tells fetch whether that consumed word is finished (advance) or must be re-presented.
   localparam logic [1:0] ST_ALIGNED = ALIGNED;

   logic            advance;
   logic [ILEN-1:0] pay_instr;
   logic [XLEN-1:0] pay_pc;
   logic            pay_valid;
   logic            pay_comp;

   assign advance = i_if_valid_instr & i_id_ready & ~i_flush;

`ifdef INSTR_ALIGN_RVC_EN
   localparam logic [1:0] ST_UPPER = UPPER;
   localparam logic [1:0] ST_SPLIT = SPLIT;

   logic [1:0]         state_q, state_d;
   logic [HW_BITS-1:0] hw_buf_q, hw_buf_d;
   logic [XLEN-1:0]    hw_buf_pc_q, hw_buf_pc_d;
   logic               incr_fsm;
   logic [HW_BITS-1:0] lo_parcel, hi_parcel;
   logic [XLEN-1:0]    upper_pc;

   assign lo_parcel = i_if_instr[HW_BITS-1:0];
   assign hi_parcel = i_if_instr[ILEN-1:HW_BITS];
   assign upper_pc  = i_if_pc + XLEN'(HW_BYTES);

   always_comb begin
      state_d     = state_q;
      hw_buf_d    = hw_buf_q;
      hw_buf_pc_d = hw_buf_pc_q;
      pay_instr   = i_if_instr;
      pay_pc      = i_if_pc;
      pay_valid   = 1'b1;
      pay_comp    = 1'b0;
      incr_fsm    = 1'b0;
      case (state_q)
         ST_ALIGNED: begin
            if (is_compressed(lo_parcel[1:0])) begin
               pay_instr = {{HW_BITS{1'b0}}, lo_parcel};
               pay_comp  = 1'b1;
               state_d   = ST_UPPER;
            end else begin
               incr_fsm  = 1'b1;
            end
         end
         ST_UPPER: begin
            incr_fsm = 1'b1;
            if (is_compressed(hi_parcel[1:0])) begin
               pay_instr = {{HW_BITS{1'b0}}, hi_parcel};
               pay_pc    = upper_pc;
               pay_comp  = 1'b1;
               state_d   = ST_ALIGNED;
            end else begin
               // Upper half opens a 32-bit instruction; finish it with the next word's low half.
               hw_buf_d    = hi_parcel;
               hw_buf_pc_d = upper_pc;
               pay_valid   = 1'b0;
               state_d     = ST_SPLIT;
            end
         end
         ST_SPLIT: begin
            pay_instr = {lo_parcel, hw_buf_q};
            pay_pc    = hw_buf_pc_q;
            state_d   = ST_UPPER;
         end
         default: begin
            state_d = ST_ALIGNED;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ALIGNED;
         hw_buf_q    <= '0;
         hw_buf_pc_q <= '0;
      end else if (i_flush) begin
         state_q     <= i_redirect_hw ? ST_UPPER : ST_ALIGNED;
         hw_buf_q    <= '0;
         hw_buf_pc_q <= '0;
      end else if (advance) begin
         state_q     <= state_d;
         hw_buf_q    <= hw_buf_d;
         hw_buf_pc_q <= hw_buf_pc_d;
      end
   end

   assign o_incr_pc   = rst_n & advance & incr_fsm;
   assign o_dbg_state = state_q;
`else
   logic unused_redirect_hw;

   assign unused_redirect_hw = i_redirect_hw;
   assign pay_instr          = i_if_instr;
   assign pay_pc             = i_if_pc;
   assign pay_valid          = 1'b1;
   assign pay_comp           = 1'b0;
   assign o_incr_pc          = rst_n & i_id_ready & i_if_valid_instr;
   assign o_dbg_state        = ST_ALIGNED;
`endif

   if_id_pipe_reg u_pipe_reg (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_flush      (i_flush),
      .i_hold       (~i_id_ready),
      .i_load       (advance),
      .i_instr      (pay_instr),
      .i_pc         (pay_pc),
      .i_valid      (pay_valid),
      .i_compressed (pay_comp),
      .o_instr      (o_id_instr),
      .o_pc         (o_id_pc),
      .o_valid      (o_id_valid),
      .o_compressed (o_id_compressed)
   );

endmodule
